// File: rtl/sensor_dgt_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the sensor/digit datapath.
// Write address and write data are captured independently; reads return the pre-edge register value.
module sensor_dgt_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   // write response channel
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   // register contents and update strobes
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
   output logic [3:0]                      reg_wr_pulse
);

   localparam int DW   = C_S_AXI_DATA_WIDTH;
   localparam int NB   = DW / 8;
   localparam int NREG = 4;
   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef logic [1:0]    reg_idx_t;
   typedef logic [DW-1:0] word_t;
   typedef logic [NB-1:0] strb_t;

   // Protection bits and the byte offset within a word carry no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // State
   logic          out_of_reset_q;
   logic          aw_held_q, aw_held_d;
   reg_idx_t      aw_idx_q,  aw_idx_d;
   logic          w_held_q,  w_held_d;
   word_t         w_data_q,  w_data_d;
   strb_t         w_strb_q,  w_strb_d;
   logic          bvalid_q,  bvalid_d;
   logic          rvalid_q,  rvalid_d;
   word_t         rdata_q,   rdata_d;
   word_t         regs_q [NREG];
   word_t         regs_d [NREG];
   logic [NREG-1:0] pulse_q, pulse_d;

   // Handshakes and the effective write transaction
   logic     aw_ready, w_ready, ar_ready;
   logic     aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic     do_write;
   reg_idx_t wr_idx;
   word_t    wr_data;
   strb_t    wr_strb;

   // Readies stay low until the first rising edge after reset is released.
   assign aw_ready = out_of_reset_q && !aw_held_q && !bvalid_q;
   assign w_ready  = out_of_reset_q && !w_held_q  && !bvalid_q;
   assign ar_ready = out_of_reset_q && !rvalid_q;

   assign aw_hs = S_AXI_AWVALID && aw_ready;
   assign w_hs  = S_AXI_WVALID  && w_ready;
   assign ar_hs = S_AXI_ARVALID && ar_ready;
   assign b_hs  = bvalid_q && S_AXI_BREADY;
   assign r_hs  = rvalid_q && S_AXI_RREADY;

   // A write commits on the edge where both halves are available, held or arriving now.
   assign do_write = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_idx   = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
   assign wr_data  = w_held_q  ? w_data_q : S_AXI_WDATA;
   assign wr_strb  = w_held_q  ? w_strb_q : S_AXI_WSTRB;

   function automatic word_t merge_bytes(input word_t old_val, input word_t new_val,
                                         input strb_t strb);
      word_t res;
      res = old_val;
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   // Write holding registers
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      if (do_write) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
         end
      end
   end

   // Register file update, strobes and write response
   always_comb begin
      for (int k = 0; k < NREG; k++) regs_d[k] = regs_q[k];
      pulse_d  = '0;
      bvalid_d = bvalid_q;
      if (b_hs) bvalid_d = 1'b0;
      if (do_write) begin
         regs_d[wr_idx]  = merge_bytes(regs_q[wr_idx], wr_data, wr_strb);
         pulse_d[wr_idx] = |wr_strb;
         bvalid_d        = 1'b1;
      end
   end

   // Read channel: data is sampled from regs_q, so a same-edge write is not yet visible.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (r_hs) rvalid_d = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         out_of_reset_q <= 1'b0;
         aw_held_q      <= 1'b0;
         aw_idx_q       <= '0;
         w_held_q       <= 1'b0;
         w_data_q       <= '0;
         w_strb_q       <= '0;
         bvalid_q       <= 1'b0;
         rvalid_q       <= 1'b0;
         rdata_q        <= '0;
         pulse_q        <= '0;
         // NOTE: the register file is four flops wide, not a RAM, and must read zero after reset.
         for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
      end else begin
         out_of_reset_q <= 1'b1;
         aw_held_q      <= aw_held_d;
         aw_idx_q       <= aw_idx_d;
         w_held_q       <= w_held_d;
         w_data_q       <= w_data_d;
         w_strb_q       <= w_strb_d;
         bvalid_q       <= bvalid_d;
         rvalid_q       <= rvalid_d;
         rdata_q        <= rdata_d;
         pulse_q        <= pulse_d;
         for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;

   assign slv_reg0     = regs_q[0];
   assign slv_reg1     = regs_q[1];
   assign slv_reg2     = regs_q[2];
   assign slv_reg3     = regs_q[3];
   assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_sensor_dgt_axil_slave.sv
// Directed bench for sensor_dgt_axil_slave: hand-computed expectations checked with
// immediate assertions, inputs driven 1 ns after the rising edge.
module tb_sensor_dgt_axil_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] reg0, reg1, reg2, reg3;
   logic [3:0]  pulse;

   int n_cmp = 0;
   int n_err = 0;

   sensor_dgt_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .slv_reg0     (reg0),
      .slv_reg1     (reg1),
      .slv_reg2     (reg2),
      .slv_reg3     (reg3),
      .reg_wr_pulse (pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] reg_at(input logic [3:0] addr);
      case (addr[3:2])
         2'd0:    return reg0;
         2'd1:    return reg1;
         2'd2:    return reg2;
         default: return reg3;
      endcase
   endfunction

   // Full write with AW and W offered together, then a one-cycle B handshake.
   task automatic do_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_reg,
                           input logic [3:0] exp_pulse);
      bit ok = 1'b0;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (awready && wready) begin ok = 1'b1; break; end
      end
      check({tag, "_accept"}, 32'(ok), 32'd1);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
      check({tag, "_bresp"},  32'(bresp),  32'd0);
      check({tag, "_reg"},    reg_at(addr), exp_reg);
      check({tag, "_pulse"},  32'(pulse),  32'(exp_pulse));
      bready = 1'b1;
      step();
      bready = 1'b0;
      check({tag, "_bclr"},   32'(bvalid), 32'd0);
      check({tag, "_pulse_off"}, 32'(pulse), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      bit ok = 1'b0;
      araddr = addr; arvalid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      check({tag, "_accept"}, 32'(ok), 32'd1);
      step();
      arvalid = 1'b0;
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "_rdata"},  rdata, exp);
      check({tag, "_rresp"},  32'(rresp), 32'd0);
      rready = 1'b1;
      step();
      rready = 1'b0;
      check({tag, "_rclr"},   32'(rvalid), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready",  32'(wready),  32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rvalid",  32'(rvalid),  32'd0);
      check("rst_rdata",   rdata, 32'd0);
      check("rst_reg0",    reg0,  32'd0);
      check("rst_reg3",    reg3,  32'd0);
      check("rst_pulse",   32'(pulse), 32'd0);
      step();
      rst_n = 1'b1;
      check("rel_awready_early", 32'(awready), 32'd0);
      step();
      check("rel_awready", 32'(awready), 32'd1);
      check("rel_arready", 32'(arready), 32'd1);

      // Write 1..4 to all registers, read back
      do_write("wr0", 4'h0, 32'h1, 4'hF, 32'h1, 4'b0001);
      do_write("wr1", 4'h4, 32'h2, 4'hF, 32'h2, 4'b0010);
      do_write("wr2", 4'h8, 32'h3, 4'hF, 32'h3, 4'b0100);
      do_write("wr3", 4'hC, 32'h4, 4'hF, 32'h4, 4'b1000);
      do_read("rd0", 4'h0, 32'h1);
      do_read("rd1", 4'h4, 32'h2);
      do_read("rd2", 4'h8, 32'h3);
      do_read("rd3", 4'hF, 32'h4);

      // W three cycles ahead of AW
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      check("wfirst_wready", 32'(wready), 32'd1);
      step();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wfirst_hold_reg1",   reg1, 32'h2);
         check("wfirst_hold_bvalid", 32'(bvalid), 32'd0);
         check("wfirst_hold_wready", 32'(wready), 32'd0);
         step();
      end
      awaddr = 4'h4; awvalid = 1'b1;
      check("wfirst_awready", 32'(awready), 32'd1);
      step();
      awvalid = 1'b0;
      check("wfirst_reg1",   reg1, 32'hDEADBEEF);
      check("wfirst_bvalid", 32'(bvalid), 32'd1);
      check("wfirst_pulse",  32'(pulse), 32'h2);
      bready = 1'b1; step(); bready = 1'b0;

      // Byte strobes
      do_write("strbF", 4'h8, 32'h11223344, 4'hF, 32'h11223344, 4'b0100);
      do_write("strb5", 4'h8, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, 4'b0100);
      do_write("strb0", 4'h8, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 4'b0000);

      // BREADY held low; a second write waits for the B handshake
      awaddr = 4'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      step();
      awaddr = 4'h0; wdata = 32'h66;
      check("bstall_reg3", reg3, 32'h55);
      for (int i = 0; i < 5; i++) begin
         check("bstall_bvalid",  32'(bvalid),  32'd1);
         check("bstall_awready", 32'(awready), 32'd0);
         check("bstall_wready",  32'(wready),  32'd0);
         check("bstall_reg0",    reg0, 32'h1);
         step();
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("bstall_bclr",     32'(bvalid),  32'd0);
      check("bstall_awready2", 32'(awready), 32'd1);
      check("bstall_reg0_pre", reg0, 32'h1);
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      check("bstall_reg0_new", reg0, 32'h66);
      check("bstall_bvalid2",  32'(bvalid), 32'd1);
      check("bstall_pulse",    32'(pulse), 32'h1);
      bready = 1'b1; step(); bready = 1'b0;

      // Read of 0x8 concurrent with a write to 0x8; RREADY low 4 cycles
      araddr = 4'h8; arvalid = 1'b1;
      awaddr = 4'h8; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      check("rw_arready", 32'(arready), 32'd1);
      check("rw_awready", 32'(awready), 32'd1);
      check("rw_wready",  32'(wready),  32'd1);
      step();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      check("rw_rvalid", 32'(rvalid), 32'd1);
      check("rw_rdata",  rdata, 32'h11BB33DD);
      check("rw_reg2",   reg2,  32'h77777777);
      check("rw_bvalid", 32'(bvalid), 32'd1);
      bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("rstall_rvalid",  32'(rvalid),  32'd1);
         check("rstall_rdata",   rdata, 32'h11BB33DD);
         check("rstall_arready", 32'(arready), 32'd0);
         step();
         bready = 1'b0;
      end
      check("rstall_bclr", 32'(bvalid), 32'd0);
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("rstall_rclr",    32'(rvalid),  32'd0);
      check("rstall_arready", 32'(arready), 32'd1);
      do_read("rd2_new", 4'h8, 32'h77777777);

      // Reset while an AW is held without W
      awaddr = 4'h4; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      check("midrst_awheld", 32'(awready), 32'd0);
      check("midrst_wready", 32'(wready),  32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_awready", 32'(awready), 32'd0);
      check("midrst_wready0", 32'(wready),  32'd0);
      check("midrst_arready", 32'(arready), 32'd0);
      check("midrst_bvalid",  32'(bvalid),  32'd0);
      check("midrst_rvalid",  32'(rvalid),  32'd0);
      check("midrst_rdata",   rdata, 32'd0);
      check("midrst_reg0",    reg0, 32'd0);
      check("midrst_reg1",    reg1, 32'd0);
      check("midrst_reg2",    reg2, 32'd0);
      check("midrst_reg3",    reg3, 32'd0);
      check("midrst_pulse",   32'(pulse), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      wdata = 32'h0000ABCD; wstrb = 4'hF; wvalid = 1'b1;
      check("post_wready", 32'(wready), 32'd1);
      step();
      wvalid = 1'b0;
      check("post_no_stale_aw", 32'(bvalid), 32'd0);
      check("post_reg1",        reg1, 32'd0);
      awaddr = 4'hC; awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      check("post_reg3",   reg3, 32'h0000ABCD);
      check("post_bvalid", 32'(bvalid), 32'd1);
      bready = 1'b1; step(); bready = 1'b0;
      do_read("post_rd3", 4'hC, 32'h0000ABCD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sensor_dgt_axil_slave.md
SENSOR_DGT_AXIL_SLAVE -- requirements
Module: sensor_dgt_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 x 32-bit registers).
REQ-003 SHALL have port S_AXI_ACLK, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have ports S_AXI_AWADDR in [ADDR_W-1:0], S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1 (write address channel).
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1 (write data channel).
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1 (write response channel).
REQ-008 SHALL have ports S_AXI_ARADDR in [ADDR_W-1:0], S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1 (read address channel).
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1 (read data channel).
REQ-010 SHALL have ports slv_reg0..slv_reg3 out 32 each, current register contents, to sensor/digit datapath.
REQ-011 SHALL have port reg_wr_pulse out 4, one-cycle strobe per register on update.

Function
REQ-012 Register map: 0x0 slv_reg0, 0x4 slv_reg1, 0x8 slv_reg2, 0xC slv_reg3; decode on ADDR[3:2], ADDR[1:0] ignored; all four read/write.
REQ-013 AWPROT/ARPROT SHALL be ignored; BRESP and RRESP SHALL always be OKAY (2'b00).
REQ-014 Write path: AW and W accepted independently into holding registers; AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
REQ-015 AW and W may arrive same cycle or in either order, any gap; no dependency on READY before VALID.
REQ-016 On the edge where both address and data are held (or handshake completes), register update SHALL occur at that edge +1 cycle visible on slv_regN, BVALID=1 same cycle, holding flags cleared.
REQ-017 Latency: AW+W handshake in cycle N -> slv_regN updated and BVALID high in cycle N+1.
REQ-018 Byte lanes: only bytes with WSTRB[i]=1 SHALL update; WSTRB=0 SHALL complete the transaction with OKAY and no change, no reg_wr_pulse.
REQ-019 reg_wr_pulse[k] SHALL be high exactly in cycle N+1 of a write to register k with nonzero WSTRB.
REQ-020 BVALID SHALL hold until BVALID&&BREADY; cleared next edge; no new AW/W accepted while BVALID high.
REQ-021 Read path: ARREADY = !RVALID; AR handshake in cycle N -> RVALID=1, RDATA=register value at edge N in cycle N+1.
REQ-022 RVALID/RDATA SHALL hold stable until RVALID&&RREADY; cleared next edge; back-to-back reads achieve one per two cycles minimum.
REQ-023 Simultaneous read and write to same register in same edge: read returns pre-write value.
REQ-024 Read and write channels SHALL operate concurrently with no mutual stalling.

Reset
REQ-025 On S_AXI_ARESETN low (asynchronous): AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; slv_reg0..3 = 0; reg_wr_pulse = 0; holding flags cleared.
REQ-026 Reset mid-transaction SHALL discard held AW/W and pending responses; no partial register update.
REQ-027 After deassertion, first handshake accepted no earlier than first rising edge with reset high.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC (WSTRB=0xF), read back -> RDATA 0x1..0x4, RRESP OKAY, BRESP OKAY.
REQ-029 W valid 3 cycles before AW to 0x4 data 0xDEADBEEF -> no update until AW handshake; slv_reg1=0xDEADBEEF and BVALID next cycle.
REQ-030 slv_reg2=0x11223344, write 0xAABBCCDD WSTRB=0x5 -> slv_reg2=0x11BB33DD; WSTRB=0 -> unchanged, OKAY, no pulse.
REQ-031 BREADY held low 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0; second write accepted only after B handshake.
REQ-032 RREADY low 4 cycles on read of 0x8 -> RDATA stable, ARREADY 0 throughout; simultaneous write to 0x8 returns old value.
REQ-033 Assert reset during held AW (W not yet given) -> all outputs 0, slv_regs 0; subsequent fresh write completes normally.
